// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request and pipeline-control response bundle for pipe_hazard_ctrl.
// HAZARD_PERF_CNT_EN adds the perf counter signals.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned RW = 4
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic          id_rs_used;
    logic [RW-1:0] id_rt;
    logic          id_rt_used;
    logic [RW-1:0] id_rd;
    logic          id_wr_en;
    logic          id_is_load;
    logic          id_is_breg;
    logic          id_is_hlt;
    logic          br_taken;
    logic          pc_we;
    logic          ifid_we;
    logic          ifid_flush;
    logic          idex_bubble;
    logic          stall;
    logic          halted;
`ifdef HAZARD_PERF_CNT_EN
    logic          perf_clr;
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en,
               id_is_load, id_is_breg, id_is_hlt, br_taken, perf_clr,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, stall, halted, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en,
               id_is_load, id_is_breg, id_is_hlt, br_taken, perf_clr,
        output pc_we, ifid_we, ifid_flush, idex_bubble, stall, halted, stall_cnt, flush_cnt
    );
`else
    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en,
               id_is_load, id_is_breg, id_is_hlt, br_taken,
        input  pc_we, ifid_we, ifid_flush, idex_bubble, stall, halted
    );
    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_rd, id_wr_en,
               id_is_load, id_is_breg, id_is_hlt, br_taken,
        output pc_we, ifid_we, ifid_flush, idex_bubble, stall, halted
    );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: X/M/W writer scoreboard, load-use and branch-register
// stalls, HLT drain into a sticky halt. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned RW        = 4,
    parameter int unsigned DRAIN_CYC = 3
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int unsigned CW = $clog2(DRAIN_CYC + 1);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic          ld;
        logic          wr;
    } sb_ent_t;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          live_q;
    sb_ent_t       sb_x_q, sb_m_q, sb_x_d;
    // W never hazards thanks to the register-file bypass, so only its occupancy is kept.
    logic          sb_w_v_q;

    logic in_run, load_use, breg, stall_w, hlt_go, flush_w;

    function automatic logic src_hit(sb_ent_t e, logic [RW-1:0] src, logic used);
        return e.v && e.wr && (e.rd == src) && (src != '0) && used;
    endfunction

    // Outputs hold their reset values until the first edge after reset release.
    assign in_run   = live_q && (state_q == RUN);
    assign load_use = sb_x_q.ld && (src_hit(sb_x_q, hz.id_rs, hz.id_rs_used) ||
                                    src_hit(sb_x_q, hz.id_rt, hz.id_rt_used));
    assign breg     = hz.id_is_breg && (src_hit(sb_x_q, hz.id_rs, hz.id_rs_used) ||
                                        (sb_m_q.ld && src_hit(sb_m_q, hz.id_rs, hz.id_rs_used)));
    assign stall_w  = in_run && hz.id_valid && (load_use || breg);
    assign hlt_go   = in_run && hz.id_valid && hz.id_is_hlt && !stall_w;
    assign flush_w  = in_run && hz.br_taken && !stall_w && !hlt_go;

    assign hz.stall       = stall_w;
    assign hz.pc_we       = in_run && !stall_w && !hlt_go;
    assign hz.ifid_we     = in_run && !stall_w && !hlt_go;
    assign hz.ifid_flush  = flush_w;
    assign hz.idex_bubble = in_run ? (stall_w || !hz.id_valid) : 1'b1;
    assign hz.halted      = (state_q == HALTED) && !sb_w_v_q;

    always_comb begin
        sb_x_d = '0;
        if (in_run && hz.id_valid && !stall_w) begin
            sb_x_d.v  = 1'b1;
            sb_x_d.rd = hz.id_rd;
            sb_x_d.ld = hz.id_is_load && !hz.id_is_hlt;
            sb_x_d.wr = hz.id_wr_en && !hz.id_is_hlt && (hz.id_rd != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (hlt_go) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(DRAIN_CYC);
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = HALTED;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            live_q   <= 1'b0;
            sb_x_q   <= '0;
            sb_m_q   <= '0;
            sb_w_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (state_q != HALTED) begin
                sb_x_q   <= sb_x_d;
                sb_m_q   <= sb_x_q;
                sb_w_v_q <= sb_m_q.v;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != HALTED) begin
            if (hz.perf_clr) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (stall_w && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
                if (flush_w && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`endif
endmodule
